// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 16x oversampling, mid-bit majority vote and receive FIFO
module uart_rx_core #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_rx_en,
  input  logic [DIV_WIDTH-1:0]          i_divisor,
  input  logic                          srx_pad_i,
  output logic [7:0]                    o_rx_data,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_frame_err,
  output logic                          o_break,
  output logic                          o_overrun,
  output logic                          o_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t               state;
  logic                 s1, s2, s3;
  logic [DIV_WIDTH-1:0] div_cnt, div_lat, div_m1;
  logic [3:0]           tcnt;
  logic [2:0]           bcnt;
  logic                 smp7, smp8;
  logic [7:0]           sh;
  logic                 push_pend;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 fall, tick, tick9, tick15, maj, pop, push;
  assign div_m1     = (i_divisor == '0) ? '0 : i_divisor - 1'b1;
  assign tick       = div_cnt == div_lat;
  assign tick9      = tick && tcnt == 4'd9;
  assign tick15     = tick && tcnt == 4'd15;
  assign fall       = s3 && !s2;
  assign maj        = (smp7 & smp8) | (smp7 & s2) | (smp8 & s2);
  assign o_busy     = state != IDLE;
  assign o_rx_valid = count != '0;
  assign o_rx_data  = mem[rd_ptr];
  assign o_fifo_count = count;
  assign pop        = o_rx_valid && i_rx_ready;
  assign push       = push_pend && (count < CW'(FIFO_DEPTH) || pop);
  assign o_overrun  = push_pend && !push;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {s1, s2, s3} <= 3'b111;
      state        <= IDLE;
      div_cnt      <= '0;
      div_lat      <= '0;
      tcnt         <= '0;
      bcnt         <= '0;
      smp7         <= 1'b1;
      smp8         <= 1'b1;
      sh           <= '0;
      push_pend    <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      s1          <= srx_pad_i;
      s2          <= s1;
      s3          <= s2;
      o_frame_err <= 1'b0;
      o_break     <= 1'b0;
      push_pend   <= 1'b0;
      // divisor is re-latched only at a wrap so a change never truncates a tick
      if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          div_lat <= div_m1;
          tcnt    <= tcnt + 1'b1;
        end
      end
      if (tick && tcnt == 4'd7) smp7 <= s2;
      if (tick && tcnt == 4'd8) smp8 <= s2;
      case (state)
        IDLE: if (fall) begin
          state   <= START;
          div_cnt <= '0;
          div_lat <= div_m1;
          tcnt    <= '0;
        end
        START: if (tick9 && maj) state <= IDLE;
          else if (tick15) begin
            state <= DATA;
            bcnt  <= '0;
          end
        DATA: begin
          if (tick9) sh <= {maj, sh[7:1]};
          if (tick15) begin
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= STOP;
          end
        end
        STOP: if (tick9) begin
          state       <= maj ? IDLE : WAIT_HIGH;
          push_pend   <= maj;
          o_frame_err <= !maj && sh != '0;
          o_break     <= !maj && sh == '0;
        end
        WAIT_HIGH: if (s2) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (!i_rx_en) state <= IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sh;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Standalone 8N1 UART receiver for the SoC serial input. It takes the raw pad-side RX line and synchronises it.
- It recovers bytes using 16x oversampling with mid-bit majority vote, and buffers them in a small FIFO.
- It presents bytes to the bus-side UART register logic over a valid/ready interface.
- It also flags framing errors, break conditions and FIFO overrun.

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries (power of 2, >=2)
- DIV_WIDTH, 16, width of oversample divisor

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- i_rx_en  input  1  receiver enable
- i_divisor  input  DIV_WIDTH  clk cycles per oversample tick (bit time = 16 ticks)
- srx_pad_i  input  1  raw serial input from pad, idle high, asynchronous
- o_rx_data  output  8  byte at FIFO head
- o_rx_valid  output  1  FIFO non-empty
- i_rx_ready  input  1  consumer accepts head byte
- o_fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes held
- o_frame_err  output  1  one-cycle pulse: stop bit sampled 0, data non-zero
- o_break  output  1  one-cycle pulse: stop bit 0 and all data bits 0
- o_overrun  output  1  one-cycle pulse: completed byte dropped, FIFO full
- o_busy  output  1  receiver not in IDLE

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - 2-flop synchroniser resets to 1.
  - FSM goes to IDLE; FIFO is emptied.
  - All outputs are 0; o_rx_data = 8'h00.
- Tick generator:
  - Counter counts 0..i_divisor-1 and emits a tick when it equals i_divisor-1, then wraps to 0.
  - i_divisor = 0 is treated as 1 (tick every clk).
  - Counter is cleared on leaving IDLE.
  - i_divisor changes take effect at the next wrap.
- Sampling:
  - Each bit spans 16 ticks, numbered 0..15.
  - Line is sampled at ticks 7, 8 and 9; the bit value is the majority of the three.
- FSM:
  - IDLE: o_busy = 0. When i_rx_en = 1 and the synchronised line falls (prev 1, now 0) -> START; tick and bit counters are cleared.
  - START: at tick 9, majority = 1 -> IDLE (false start, nothing reported). At tick 15 -> DATA.
  - DATA: 8 bits, LSB first, each shifted in at tick 9. After tick 15 of bit 7 -> STOP.
  - STOP, decided at tick 9:
    - stop = 1: byte pushed to FIFO -> IDLE (resync at mid-stop, no wait for bit end).
    - stop = 0 and data != 0: o_frame_err pulses, byte discarded -> WAIT_HIGH.
    - stop = 0 and data == 0: o_break pulses, byte discarded -> WAIT_HIGH.
  - WAIT_HIGH: stays until the synchronised line = 1 -> IDLE. No further error pulses during a long break.
  - i_rx_en deasserted in any state -> IDLE next cycle. Partial byte is dropped; FIFO contents are kept.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count.
  - o_rx_valid = (count != 0); o_rx_data = mem[rd_ptr], combinational from storage.
  - Pop when o_rx_valid & i_rx_ready.
  - Push when STOP completes with stop = 1 and (count < FIFO_DEPTH or pop in the same cycle).
  - If full and no pop: byte dropped, o_overrun pulses, count unchanged.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - Byte is written at the clk after the stop-bit tick-9 tick.
  - o_rx_valid rises on the following clk edge.
  - Error and overrun pulses occur in the same cycle as the would-be push.
- Only one of o_frame_err, o_break, o_overrun may be high in any cycle.

Test Plan:
1. i_divisor = 4 (64 clk/bit), rx_en = 1, ready = 1, send 0xA5 with stop = 1 -> o_rx_valid high for 1 cycle with o_rx_data = 0xA5, ~600 clks after the start edge; no error pulses; o_busy returns to 0.
2. 20-clk low glitch on srx_pad_i -> FSM returns to IDLE after the START tick-9 check; o_fifo_count stays 0; no pulses.
3. Send 0x3C with stop = 0, then line high -> o_frame_err single pulse; count stays 0; next frame 0x5A is received correctly.
4. Hold line low for 12 bit times, then high -> exactly one o_break pulse, no o_frame_err, count 0, IDLE after the line rises.
5. FIFO_DEPTH = 8, ready = 0, send 0x01..0x09 -> count = 8, one o_overrun pulse on 0x09; then ready = 1 drains 0x01..0x08 in order. Repeat with ready pulsed in the push cycle while full -> no overrun, count stays 8.
6. Assert reset_n low mid-DATA of 0x77 with FIFO holding 3 bytes -> immediately count = 0, o_rx_valid = 0, o_busy = 0. After release, 0x81 is received correctly.
